la_trigger_capture: RTL
=======================

# la_trigger_capture

Parametrised multi-channel logic-analyser capture engine for the digital signal analyser path. It samples `CH` digital channels into a `DEPTH`-entry circular buffer and evaluates a per-channel edge/level trigger combined by AND or OR. It retains a programmable number of pre-trigger samples and freezes the buffer after the post-trigger window. A host-side reader then fetches samples in chronological order through a synchronous read port.

## Interface
Parameters:
- `CH`, 8: number of input channels (1..32).
- `DEPTH`, 1024: buffer entries; must be a power of two ≥ 4.
- `AW`, $clog2(DEPTH): buffer address width.
- `TSW`, 32: trigger timestamp width.

Ports:
- `sys_clk` in 1: single clock for the block.
- `sys_rst` in 1: reset, synchronous, active-high.
- `sig_in` in CH: channel inputs, already synchronised to `sys_clk`.
- `sample_en` in 1: sample strobe; capture and trigger logic advance only when it is high.
- `arm` in 1: one-cycle pulse that starts a capture; ignored unless the block is in IDLE or DONE.
- `abort` in 1: one-cycle pulse that returns the block to IDLE from any state.
- `force_trig` in 1: treats the current sample as the trigger while in WAIT_TRIG.
- `trig_cond` in 3*CH: per-channel condition, 3 bits per channel [3c+2:3c]: 000 ignore, 001 rising, 010 falling, 011 any edge, 100 low, 101 high, 11x ignore.
- `trig_or` in 1: combine mode; 0 = AND of non-ignored channels, 1 = OR of non-ignored channels.
- `pre_cnt` in AW: number of pre-trigger samples, 0..DEPTH-1.
- `rd_addr` in AW: chronological read index; 0 = oldest sample.
- `rd_data` out CH: sample at `rd_addr`, one-cycle latency.
- `busy` out 1: high in FILL, WAIT_TRIG and POST.
- `triggered` out 1: trigger has occurred in the current capture.
- `done` out 1: buffer frozen and valid.
- `trig_ts` out TSW: count of `sample_en` strobes from arm to the trigger sample (first sample = 0).

## Operation
States: IDLE, FILL, WAIT_TRIG, POST, DONE.
- IDLE/DONE + `arm`:
  - Clear `wr_ptr`, counters, `triggered`, `done`, and `trig_ts`.
  - Latch `pre_cnt`, `trig_cond`, and `trig_or`; these are stable for the whole capture.
  - Go to FILL, or directly to WAIT_TRIG if `pre_cnt` = 0.
- Every `sample_en` in FILL/WAIT_TRIG/POST:
  - Write `sig_in` to `mem[wr_ptr]` and increment `wr_ptr` modulo DEPTH.
  - Store the sample in `prev`.
  - Increment the timestamp counter, which saturates at all-ones.
- FILL: after `pre_cnt` writes, go to WAIT_TRIG. No trigger evaluation in FILL.
- WAIT_TRIG: on a `sample_en` cycle where the trigger is true or `force_trig` is high:
  - The current sample is the trigger sample.
  - Record `trig_addr = wr_ptr` and `trig_ts = ` the current count.
  - Set `triggered` and go to POST.
  - The buffer keeps wrapping while waiting; no overflow condition exists.
- Trigger evaluation:
  - Edge conditions compare `sig_in` against `prev`.
  - On the first sample after arm, no `prev` exists: edge conditions evaluate false, level conditions evaluate normally.
  - All channels ignored: AND result is false, OR result is false; only `force_trig` can trigger.
- POST: write DEPTH-1-`pre_cnt` further samples, then go to DONE and set `done`. If that count is 0, go to DONE directly after the trigger write.
- DONE: no writes.
  - `start = (trig_addr - pre_cnt) mod DEPTH`.
  - `rd_data <= mem[(start + rd_addr) mod DEPTH]`.
  - Reads are also permitted in other states; data is undefined until `done`.
- `abort`: go to IDLE and clear `busy`, `triggered`, and `done`. `abort` wins over a simultaneous `arm`. Buffer contents are left unchanged.
- `arm` while `busy`: ignored.

## Timing
- Reset values: state IDLE, `busy`=0, `triggered`=0, `done`=0, `trig_ts`=0, `rd_data`=0, `prev`=0. Memory contents are not reset.
- `sys_rst` mid-capture forces all reset values on the next edge.
- Latencies:
  - `arm` → `busy`=1 on the next cycle.
  - Trigger sample cycle → `triggered`=1 on the next cycle.
  - Last POST write → `done`=1 and `busy`=0 on the next cycle.
  - `rd_addr` → `rd_data`: one cycle.
- `sample_en` low: the state machine holds, except for `arm`/`abort` handling.
- `force_trig` or the trigger condition is effective only in a WAIT_TRIG cycle with `sample_en`=1.
- Exactly DEPTH samples are valid at `done`. Index `pre_cnt` is always the trigger sample.

## Test plan
Bench configuration: CH=4, DEPTH=16, `sample_en`=1 every cycle unless stated otherwise.
- **Rising-edge trigger:** ch0 cond=001, `pre_cnt`=4, `sig_in` = counter 0,1,2… with ch0 toggling; arm. Trigger fires on the first 0→1 after FILL. At `done`: read 0..15 gives consecutive counts, `rd_addr` 4 = trigger value, `trig_ts` matches.
- **AND combination:** ch0=001, ch1=101, `trig_or`=0; ch1 high only over one ch0 rising edge. The trigger lands on that edge only; an earlier ch0 rising edge with ch1=0 is ignored.
- **Extreme `pre_cnt` values:**
  - `pre_cnt`=0 → FILL is skipped and `rd_addr` 0 is the trigger sample.
  - `pre_cnt`=15 → `done` on the cycle after the trigger, and `rd_addr` 15 is the trigger sample.
- **Wrap while waiting:** hold `sig_in` static for 40 samples, then `force_trig`. `trig_ts`=40 and `rd_addr` 0..3 are the 4 samples before it, correctly handling buffer wrap.
- **Abort and reset:**
  - `abort` in WAIT_TRIG → IDLE next cycle, all flags 0.
  - `abort`+`arm` in the same cycle → IDLE.
  - `sys_rst` in POST → all outputs at reset values.
- **Gated sampling and edge suppression:** `sample_en` one cycle in four. The trigger timestamp counts strobes, not clocks. An edge present on the first sample after arm does not trigger.

Source files
------------

// File: rtl/la_trigger_capture.sv
// la_trigger_capture
//   Multi-channel logic-analyser capture engine. Samples CH channels into a
//   DEPTH-entry circular buffer and evaluates a per-channel edge/level trigger
//   combined by AND or OR. It keeps pre_cnt pre-trigger samples and freezes
//   the buffer once the post-trigger window is full. A host reads samples back
//   in chronological order (rd_addr 0 = oldest) with one cycle of latency.
//
// Ports
//   sys_clk, sys_rst  : clock, synchronous active-high reset
//   sig_in            : channel inputs (already synchronous to sys_clk)
//   sample_en         : sample strobe; capture/trigger logic advance only on it
//   arm, abort        : start a capture / return to IDLE (abort wins)
//   force_trig        : take the current sample as the trigger (WAIT_TRIG only)
//   trig_cond         : 3 bits per channel: 001 rise, 010 fall, 011 any edge,
//                       100 low, 101 high, others ignore
//   trig_or           : 0 = AND of used channels, 1 = OR of used channels
//   pre_cnt           : number of pre-trigger samples
//   rd_addr, rd_data  : chronological read port
//   busy, triggered, done, trig_ts : status and trigger timestamp
module la_trigger_capture #(
  parameter int CH    = 8,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int TSW   = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [CH-1:0]     sig_in,
  input  logic              sample_en,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [3*CH-1:0]   trig_cond,
  input  logic              trig_or,
  input  logic [AW-1:0]     pre_cnt,
  input  logic [AW-1:0]     rd_addr,
  output logic [CH-1:0]     rd_data,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [TSW-1:0]    trig_ts
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_POST, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     pre_q, pre_d;
  logic [AW-1:0]     trig_addr_q, trig_addr_d;
  logic [3*CH-1:0]   cond_q, cond_d;
  logic              or_q, or_d;
  logic [CH-1:0]     prev_q, prev_d;
  logic              first_q, first_d;
  logic [TSW-1:0]    ts_q, ts_d;
  logic [TSW-1:0]    trig_ts_q, trig_ts_d;
  logic [CH-1:0]     rd_data_q;
  logic              mem_we;

  logic [CH-1:0]     mem [DEPTH];

  // Per-channel trigger evaluation. Edges are suppressed on the first sample
  // after arm because prev does not yet hold a sample of this capture.
  logic [CH-1:0]     care;
  logic [CH-1:0]     match;
  logic              trig_hit;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [2:0] c;
    logic       rise, fall, c_care, c_match;
    assign c    = cond_q[3*gi +: 3];
    assign rise = sig_in[gi] & ~prev_q[gi] & ~first_q;
    assign fall = ~sig_in[gi] & prev_q[gi] & ~first_q;
    always_comb begin
      c_care  = 1'b1;
      c_match = 1'b0;
      case (c)
        3'b001:  c_match = rise;
        3'b010:  c_match = fall;
        3'b011:  c_match = rise | fall;
        3'b100:  c_match = ~sig_in[gi];
        3'b101:  c_match = sig_in[gi];
        default: c_care  = 1'b0;
      endcase
    end
    assign care[gi]  = c_care;
    assign match[gi] = c_match;
  end

  // With no channel in use both modes yield false; only force_trig triggers.
  assign trig_hit = or_q ? |(match & care)
                         : (|care) & (&(match | ~care));

  // Post-trigger writes = DEPTH-1-pre, which in AW bits is simply ~pre.
  logic [AW-1:0] post_len;
  assign post_len = ~pre_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    trig_addr_d = trig_addr_q;
    cond_d      = cond_q;
    or_d        = or_q;
    prev_d      = prev_q;
    first_d     = first_q;
    ts_d        = ts_q;
    trig_ts_d   = trig_ts_q;
    mem_we      = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            wr_ptr_d  = '0;
            cnt_d     = '0;
            ts_d      = '0;
            trig_ts_d = '0;
            first_d   = 1'b1;
            pre_d     = pre_cnt;
            cond_d    = trig_cond;
            or_d      = trig_or;
            state_d   = (pre_cnt == '0) ? S_WAIT : S_FILL;
          end
        end
        default: begin
          if (sample_en) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            prev_d   = sig_in;
            first_d  = 1'b0;
            if (ts_q != {TSW{1'b1}}) ts_d = ts_q + TSW'(1);
            case (state_q)
              S_FILL: begin
                if (cnt_q == pre_q - AW'(1)) begin
                  cnt_d   = '0;
                  state_d = S_WAIT;
                end else begin
                  cnt_d = cnt_q + AW'(1);
                end
              end
              S_WAIT: begin
                if (trig_hit || force_trig) begin
                  trig_addr_d = wr_ptr_q;
                  trig_ts_d   = ts_q;
                  cnt_d       = '0;
                  state_d     = (post_len == '0) ? S_DONE : S_POST;
                end
              end
              default: begin
                if (cnt_q == post_len - AW'(1)) begin
                  state_d = S_DONE;
                end else begin
                  cnt_d = cnt_q + AW'(1);
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      pre_q       <= '0;
      trig_addr_q <= '0;
      cond_q      <= '0;
      or_q        <= 1'b0;
      prev_q      <= '0;
      first_q     <= 1'b1;
      ts_q        <= '0;
      trig_ts_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      trig_addr_q <= trig_addr_d;
      cond_q      <= cond_d;
      or_q        <= or_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      ts_q        <= ts_d;
      trig_ts_q   <= trig_ts_d;
    end
  end

  // Buffer storage is not reset so it maps onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (mem_we) mem[wr_ptr_q] <= sig_in;
  end

  // Chronological read: oldest retained sample sits pre samples before trigger.
  logic [AW-1:0] rd_idx;
  assign rd_idx = trig_addr_q - pre_q + rd_addr;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) rd_data_q <= '0;
    else         rd_data_q <= mem[rd_idx];
  end

  assign rd_data   = rd_data_q;
  assign busy      = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_POST);
  assign triggered = (state_q == S_POST) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign trig_ts   = trig_ts_q;

endmodule
